// File: rtl/hr_pkg.sv
// rtl/hr_pkg.sv - shared types and constants for the HyperRAM read-capture path
package hr_pkg;

    localparam int HR_WORD_W = 16;
    localparam int HR_BYTE_W = 8;

    // A cycle carries a valid word when RWDS is high on the fall sample and low on the rise sample
    localparam logic RWDS_QUAL_FAL = 1'b1;
    localparam logic RWDS_QUAL_RIS = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } hr_state_t;

    function automatic logic rwds_qualified(input logic fal, input logic ris);
        return (fal == RWDS_QUAL_FAL) && (ris == RWDS_QUAL_RIS);
    endfunction

endpackage

// File: rtl/hr_rd_fifo.sv
// rtl/hr_rd_fifo.sv - synchronous first-word fall-through FIFO with full/empty flags
module hr_rd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && !do_push;
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/hr_rd_capture.sv
// rtl/hr_rd_capture.sv - HyperRAM read-data capture, burst count, timeout and output FIFO (option: HR_RD_CAPTURE_LAT_MEAS_EN)
module hr_rd_capture
    import hr_pkg::*;
#(
    parameter int LEN_BITS    = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [HR_BYTE_W-1:0] dq_ris,
    input  logic [HR_BYTE_W-1:0] dq_fal,
    input  logic                 rwds_ris,
    input  logic                 rwds_fal,
    input  logic                 rd_start,
    input  logic [LEN_BITS-1:0]  rd_len,
    output logic                 busy,
    output logic                 rd_done,
    output logic                 rd_timeout,
    output logic                 rd_ovfl,
    output logic [HR_WORD_W-1:0] dout_data,
    output logic                 dout_valid,
    input  logic                 dout_ready
`ifdef HR_RD_CAPTURE_LAT_MEAS_EN
    ,
    output logic [7:0]           lat_cycles
`endif
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    hr_state_t            state;
    hr_state_t            state_nxt;
    logic [LEN_BITS-1:0]  remaining;
    logic [LEN_BITS-1:0]  remaining_nxt;
    logic [TO_W-1:0]      to_cnt;
    logic [TO_W-1:0]      to_cnt_nxt;
    logic                 in_qual_r;
    logic [HR_WORD_W-1:0] in_data_r;
    logic                 done_nxt;
    logic                 timeout_nxt;
    logic                 push;
    logic                 arm;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_drop;

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        to_cnt_nxt    = to_cnt;
        done_nxt      = 1'b0;
        timeout_nxt   = 1'b0;
        push          = 1'b0;
        arm           = 1'b0;
        case (state)
            IDLE: begin
                if (rd_start) begin
                    if (rd_len != '0) begin
                        arm           = 1'b1;
                        remaining_nxt = rd_len;
                        to_cnt_nxt    = '0;
                        state_nxt     = WAIT;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            WAIT, BURST: begin
                if (in_qual_r) begin
                    push          = 1'b1;
                    to_cnt_nxt    = '0;
                    remaining_nxt = remaining - 1'b1;
                    // A one-word burst finishes straight out of WAIT so rd_done tracks the final push
                    if (remaining == LEN_BITS'(1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = BURST;
                    end
                end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    timeout_nxt = 1'b1;
                    to_cnt_nxt  = '0;
                    state_nxt   = IDLE;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            remaining  <= '0;
            to_cnt     <= '0;
            rd_done    <= 1'b0;
            rd_timeout <= 1'b0;
            rd_ovfl    <= 1'b0;
            in_qual_r  <= 1'b0;
            in_data_r  <= '0;
        end else begin
            state      <= state_nxt;
            remaining  <= remaining_nxt;
            to_cnt     <= to_cnt_nxt;
            rd_done    <= done_nxt;
            rd_timeout <= timeout_nxt;
            in_qual_r  <= rwds_qualified(rwds_fal, rwds_ris);
            in_data_r  <= {dq_fal, dq_ris};
            if (arm)            rd_ovfl <= 1'b0;
            else if (fifo_drop) rd_ovfl <= 1'b1;
        end
    end

    assign busy       = (state != IDLE);
    assign dout_valid = !fifo_empty;

    hr_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (HR_WORD_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (in_data_r),
        .pop       (dout_ready),
        .pop_data  (dout_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

`ifdef HR_RD_CAPTURE_LAT_MEAS_EN
    logic [7:0] lat_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lat_cnt    <= '0;
            lat_cycles <= '0;
        end else begin
            if (arm) begin
                lat_cnt <= '0;
            end else if (state == WAIT && lat_cnt != 8'hFF) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
            if (state == WAIT && in_qual_r) lat_cycles <= lat_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_hr_rd_capture.sv
// tb/tb_hr_rd_capture.sv - self-checking bench for hr_rd_capture with a word-level reference model
module tb_hr_rd_capture;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  dq_ris = '0;
    logic [7:0]  dq_fal = '0;
    logic        rwds_ris = 1'b0;
    logic        rwds_fal = 1'b0;
    logic        rd_start = 1'b0;
    logic [7:0]  rd_len = '0;
    logic        busy;
    logic        rd_done;
    logic        rd_timeout;
    logic        rd_ovfl;
    logic [15:0] dout_data;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
`ifdef HR_RD_CAPTURE_LAT_MEAS_EN
    logic [7:0]  lat_cycles;
`endif

    hr_rd_capture dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dq_ris     (dq_ris),
        .dq_fal     (dq_fal),
        .rwds_ris   (rwds_ris),
        .rwds_fal   (rwds_fal),
        .rd_start   (rd_start),
        .rd_len     (rd_len),
        .busy       (busy),
        .rd_done    (rd_done),
        .rd_timeout (rd_timeout),
        .rd_ovfl    (rd_ovfl),
        .dout_data  (dout_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
`ifdef HR_RD_CAPTURE_LAT_MEAS_EN
        ,
        .lat_cycles (lat_cycles)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    int          armed = 0;
    int          rem = 0;
    int          exp_done = 0;
    int          exp_to = 0;
    int          done_cnt = 0;
    int          to_cnt = 0;
    logic        exp_ovfl = 1'b0;
    bit          rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
        if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) check("spurious_valid", 32'(dout_valid), 32'd0);
            else                   check("dout_data", 32'(dout_data), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
        if (rd_done)    done_cnt++;
        if (rd_timeout) to_cnt++;
        rd_start = 1'b0;
        rwds_fal = 1'b0;
        rwds_ris = 1'b0;
    endtask

    task automatic start(input int len);
        rd_start = 1'b1;
        rd_len   = 8'(len);
        if (armed == 0) begin
            if (len == 0) begin
                exp_done++;
            end else begin
                armed    = 1;
                rem      = len;
                exp_ovfl = 1'b0;
            end
        end
        cycle();
    endtask

    task automatic word(input logic [7:0] f, input logic [7:0] r);
        dq_fal   = f;
        dq_ris   = r;
        rwds_fal = 1'b1;
        rwds_ris = 1'b0;
        if (armed != 0) begin
            if (exp_q.size() < 8) exp_q.push_back({f, r});
            else                  exp_ovfl = 1'b1;
            rem--;
            if (rem == 0) begin
                armed = 0;
                exp_done++;
            end
        end
        cycle();
    endtask

    task automatic junk();
        int p;
        p        = int'($urandom_range(0, 2));
        dq_fal   = 8'($urandom);
        dq_ris   = 8'($urandom);
        rwds_fal = (p == 2);
        rwds_ris = (p != 0);
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) junk();
    endtask

    task automatic drain();
        int guard;
        guard      = 0;
        rand_ready = 1'b0;
        dout_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 100) begin
            junk();
            guard++;
        end
        idle(2);
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(dout_valid), 32'd0);
    endtask

    task automatic rand_word();
        word(8'($urandom), 8'($urandom));
    endtask

    initial begin
        int hit;
        int len;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(rd_done), 32'd0);
        check("rst_timeout", 32'(rd_timeout), 32'd0);
        check("rst_ovfl", 32'(rd_ovfl), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_data", 32'(dout_data), 32'd0);
        reset_n    = 1'b1;
        dout_ready = 1'b1;
        idle(2);

        word(8'h55, 8'h66);
        idle(3);
        check("idle_word_ignored", 32'(dout_valid), 32'd0);

        start(4);
        word(8'hA1, 8'hB2);
        word(8'hC3, 8'hD4);
        word(8'hE5, 8'hF6);
        word(8'h07, 8'h18);
        idle(3);
        check("basic_done", 32'(done_cnt), 32'(exp_done));
        check("basic_busy", 32'(busy), 32'd0);
        drain();

        start(3);
        word(8'h11, 8'h22);
        idle(5);
        word(8'h33, 8'h44);
        word(8'h55, 8'h66);
        idle(3);
        check("gap_done", 32'(done_cnt), 32'(exp_done));
        check("gap_no_timeout", 32'(to_cnt), 32'd0);
        drain();

        start(0);
        check("len0_done_pulse", 32'(rd_done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        idle(1);
        check("len0_done_low", 32'(rd_done), 32'd0);
        check("len0_done_cnt", 32'(done_cnt), 32'(exp_done));

        start(3);
        word(8'h9A, 8'hBC);
        start(5);
        check("restart_busy", 32'(busy), 32'd1);
        word(8'hDE, 8'hF0);
        word(8'h12, 8'h34);
        idle(3);
        check("restart_done", 32'(done_cnt), 32'(exp_done));
        check("restart_idle", 32'(busy), 32'd0);
        drain();

        start(2);
        hit = 0;
        for (int i = 1; i <= 100; i++) begin
            junk();
            if (i == 1) check("to_busy", 32'(busy), 32'd1);
            if (rd_timeout) begin
                hit = i;
                break;
            end
        end
        armed = 0;
        exp_to++;
        check("to_cycle", 32'(hit), 32'd64);
        check("to_busy_after", 32'(busy), 32'd0);
        check("to_fifo_empty", 32'(dout_valid), 32'd0);
        idle(1);
        check("to_pulse_low", 32'(rd_timeout), 32'd0);
        check("to_cnt", 32'(to_cnt), 32'(exp_to));

        dout_ready = 1'b0;
        start(10);
        for (int i = 0; i < 10; i++) rand_word();
        idle(3);
        check("ovf_valid", 32'(dout_valid), 32'd1);
        check("ovf_flag", 32'(rd_ovfl), 32'(exp_ovfl));
        check("ovf_done", 32'(done_cnt), 32'(exp_done));
        check("ovf_busy", 32'(busy), 32'd0);
        drain();

        for (int b = 0; b < 6; b++) begin
            rand_ready = 1'b1;
            len = int'($urandom_range(1, 8));
            start(len);
            for (int w = 0; w < len; w++) begin
                rand_word();
                idle(int'($urandom_range(0, 3)));
            end
            idle(3);
            check("rand_done", 32'(done_cnt), 32'(exp_done));
            check("rand_busy", 32'(busy), 32'd0);
            check("rand_ovfl", 32'(rd_ovfl), 32'(exp_ovfl));
            drain();
        end

        dout_ready = 1'b0;
        start(12);
        for (int i = 0; i < 10; i++) rand_word();
        idle(2);
        check("pre_rst_ovfl", 32'(rd_ovfl), 32'(exp_ovfl));
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        cycle();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(rd_done), 32'd0);
        check("mid_rst_timeout", 32'(rd_timeout), 32'd0);
        check("mid_rst_ovfl", 32'(rd_ovfl), 32'd0);
        check("mid_rst_valid", 32'(dout_valid), 32'd0);
        check("mid_rst_data", 32'(dout_data), 32'd0);
        reset_n = 1'b1;
        exp_q.delete();
        armed = 0;
        idle(70);
        check("post_rst_done", 32'(done_cnt), 32'(exp_done));
        check("post_rst_timeout", 32'(to_cnt), 32'(exp_to));
        check("post_rst_busy", 32'(busy), 32'd0);

`ifdef HR_RD_CAPTURE_LAT_MEAS_EN
        dout_ready = 1'b1;
        start(1);
        idle(11);
        word(8'hCA, 8'hFE);
        idle(2);
        check("lat_cycles", 32'(lat_cycles), 32'd12);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
